// File: rtl/calculator_pkg.sv
// Shared calculator types: datapath width, result width, subtract FSM states.
package calculator_pkg;
    localparam int DATA_W   = 32;
    localparam int RESULT_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } sub_state_e;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used by the calculator adder/subtractor chains.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/subtractor32.sv
// Combinational W-bit subtract slice: a + ~b + ~borrow_i, borrow_o = ~carry.
module subtractor32 #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         borrow_i,
    output logic [W-1:0] diff,
    output logic         borrow_o
);
    logic [W:0] carry;

    assign carry[0] = ~borrow_i;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (~b[i]),
            .cin  (carry[i]),
            .sum  (diff[i]),
            .cout (carry[i+1])
        );
    end

    assign borrow_o = ~carry[W];
endmodule

// File: rtl/sub64_seq.sv
// Two-cycle 2*SLICE_W subtractor reusing one slice; low half then high half.
// Optional SUB64_OVERFLOW_EN adds a registered signed overflow output.
module sub64_seq
    import calculator_pkg::*;
#(
    parameter int SLICE_W = DATA_W
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [2*SLICE_W-1:0] a_i,
    input  logic [2*SLICE_W-1:0] b_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*SLICE_W-1:0] diff_o,
`ifdef SUB64_OVERFLOW_EN
    output logic                 overflow_o,
`endif
    output logic                 borrow_o
);
    localparam int W2 = 2 * SLICE_W;

    sub_state_e         state;
    logic [W2-1:0]      a_q;
    logic [W2-1:0]      b_q;
    logic [SLICE_W-1:0] lo_diff_q;
    logic               lo_borrow_q;
    logic [W2-1:0]      diff_q;
    logic               borrow_q;

    logic               is_hi;
    logic [SLICE_W-1:0] s_a;
    logic [SLICE_W-1:0] s_b;
    logic               s_bin;
    logic [SLICE_W-1:0] s_diff;
    logic               s_bout;

    assign is_hi = (state == HI);
    assign s_a   = is_hi ? a_q[W2-1:SLICE_W] : a_q[SLICE_W-1:0];
    assign s_b   = is_hi ? b_q[W2-1:SLICE_W] : b_q[SLICE_W-1:0];
    assign s_bin = is_hi & lo_borrow_q;

    subtractor32 #(.W(SLICE_W)) u_slice (
        .a        (s_a),
        .b        (s_b),
        .borrow_i (s_bin),
        .diff     (s_diff),
        .borrow_o (s_bout)
    );

    // Low half is staged separately so diff_o keeps the old result until HI.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            lo_diff_q   <= '0;
            lo_borrow_q <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        a_q   <= a_i;
                        b_q   <= b_i;
                        state <= LO;
                    end
                end
                LO: begin
                    lo_diff_q   <= s_diff;
                    lo_borrow_q <= s_bout;
                    state       <= HI;
                end
                HI: begin
                    diff_q   <= {s_diff, lo_diff_q};
                    borrow_q <= s_bout;
                    state    <= DONE;
                end
                DONE: begin
                    if (out_ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SUB64_OVERFLOW_EN
    logic ovf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else if (is_hi) begin
            ovf_q <= (a_q[W2-1] != b_q[W2-1]) && (s_diff[SLICE_W-1] != a_q[W2-1]);
        end
    end

    assign overflow_o = ovf_q;
`endif

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);
    assign diff_o      = diff_q;
    assign borrow_o    = borrow_q;
endmodule
